// File: rtl/aud_dsp.sv
// Playback DSP between recording SRAM and the I2S serializer: fetches samples once per
// LRC period and applies fast (decimate) or slow (hold / linear interpolate) speed control.
module aud_dsp #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_fast,
    input  logic [2:0]        i_speed,
    input  logic              i_interp,
    input  logic              i_daclrck,
    input  logic [ADDR_W-1:0] i_end_addr,
    input  logic [DATA_W-1:0] i_sram_data,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_dac_data,
    output logic              o_player_en,
    output logic              o_done
);

    localparam int unsigned NUM_W = DATA_W + 4;
    localparam int unsigned CNT_W = $clog2(DATA_W);

    typedef enum logic [3:0] {
        StIdle, StPlayWait, StFetch0, StCap0, StFetch1, StCap1, StCalc, StOut, StPaused
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] a_q;
    logic [2:0]        c_q;
    logic [3:0]        k_q;
    logic              fast_q;
    logic              interp_q;
    logic              lrc_prev_q;
    logic [DATA_W-1:0] s0_q;
    logic [DATA_W-1:0] dq_q;
    logic [3:0]        rem_q;
    logic              neg_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              tick;
    logic              is_play;
    logic [3:0]        k_in;
    logic [ADDR_W:0]   a_ext;
    logic [ADDR_W:0]   end_ext;
    logic              at_last;
    logic              bypass;
    logic signed [NUM_W-1:0] s0_x, s1_x, kmc_x, c_x, num;
    logic [NUM_W-1:0]  mag;
    logic [4:0]        trial;
    logic              ge;
    logic [3:0]        rem_sub;
    logic [3:0]        rem_nxt;
    logic [DATA_W-1:0] res;
    logic [ADDR_W:0]   a_nxt;
    logic [2:0]        c_nxt;
    logic              finished;

    assign tick    = i_daclrck & ~lrc_prev_q;
    assign is_play = state_q inside {StPlayWait, StFetch0, StCap0, StFetch1, StCap1, StCalc, StOut};
    assign k_in    = {1'b0, i_speed} + 4'd1;
    assign a_ext   = {1'b0, a_q};
    assign end_ext = {1'b0, i_end_addr};
    // a+1 beyond the end: s1 would be past the recording, so the result is just s0
    assign at_last = a_ext >= end_ext;
    assign bypass  = fast_q || !interp_q || (c_q == 3'd0) || at_last;

    always_comb begin
        s0_x  = {{4{s0_q[DATA_W-1]}}, s0_q};
        s1_x  = {{4{i_sram_data[DATA_W-1]}}, i_sram_data};
        kmc_x = {{(NUM_W-4){1'b0}}, k_q - {1'b0, c_q}};
        c_x   = {{(NUM_W-3){1'b0}}, c_q};
        num   = s0_x * kmc_x + s1_x * c_x;
        mag   = num[NUM_W-1] ? NUM_W'(-num) : NUM_W'(num);
    end

    // Restoring divide on the magnitude; |num| < k * 2^DATA_W so the top nibble
    // is already a valid partial remainder and DATA_W iterations suffice.
    always_comb begin
        trial   = {rem_q, dq_q[DATA_W-1]};
        ge      = trial >= {1'b0, k_q};
        rem_sub = trial[3:0] - k_q;
        rem_nxt = ge ? rem_sub : trial[3:0];
        res     = neg_q ? -dq_q : dq_q;
    end

    always_comb begin
        a_nxt = a_ext;
        c_nxt = c_q;
        if (fast_q) begin
            a_nxt = a_ext + (ADDR_W+1)'(k_q);
        end else if ({1'b0, c_q} == k_q - 4'd1) begin
            c_nxt = 3'd0;
            a_nxt = a_ext + (ADDR_W+1)'(1);
        end else begin
            c_nxt = c_q + 3'd1;
        end
        finished = a_nxt > end_ext;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            c_q         <= '0;
            k_q         <= 4'd1;
            fast_q      <= 1'b0;
            interp_q    <= 1'b0;
            lrc_prev_q  <= 1'b0;
            s0_q        <= '0;
            dq_q        <= '0;
            rem_q       <= '0;
            neg_q       <= 1'b0;
            cnt_q       <= '0;
            o_sram_addr <= '0;
            o_dac_data  <= '0;
            o_player_en <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            lrc_prev_q <= i_daclrck;
            o_done     <= 1'b0;
            if (i_stop) begin
                state_q     <= StIdle;
                a_q         <= '0;
                c_q         <= '0;
                o_dac_data  <= '0;
                o_player_en <= 1'b0;
            end else if (i_pause && is_play) begin
                state_q     <= StPaused;
                o_dac_data  <= '0;
                o_player_en <= 1'b0;
            end else begin
                case (state_q)
                    StIdle, StPaused: begin
                        if (i_start && !i_pause) begin
                            state_q     <= StPlayWait;
                            o_player_en <= 1'b1;
                        end
                    end
                    StPlayWait: begin
                        if (tick) begin
                            fast_q      <= i_fast;
                            interp_q    <= i_interp;
                            k_q         <= k_in;
                            if ({1'b0, c_q} >= k_in) c_q <= 3'd0;
                            o_sram_addr <= a_q;
                            state_q     <= StFetch0;
                        end
                    end
                    StFetch0: state_q <= StCap0;
                    StCap0: begin
                        if (bypass) begin
                            dq_q    <= i_sram_data;
                            neg_q   <= 1'b0;
                            state_q <= StOut;
                        end else begin
                            s0_q        <= i_sram_data;
                            o_sram_addr <= a_q + ADDR_W'(1);
                            state_q     <= StFetch1;
                        end
                    end
                    StFetch1: state_q <= StCap1;
                    StCap1: begin
                        rem_q   <= mag[NUM_W-1:DATA_W];
                        dq_q    <= mag[DATA_W-1:0];
                        neg_q   <= num[NUM_W-1];
                        cnt_q   <= '0;
                        state_q <= StCalc;
                    end
                    StCalc: begin
                        rem_q <= rem_nxt;
                        dq_q  <= {dq_q[DATA_W-2:0], ge};
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DATA_W - 1)) state_q <= StOut;
                    end
                    StOut: begin
                        o_dac_data <= res;
                        if (finished) begin
                            state_q     <= StIdle;
                            a_q         <= '0;
                            c_q         <= '0;
                            o_player_en <= 1'b0;
                            o_done      <= 1'b1;
                        end else begin
                            a_q     <= a_nxt[ADDR_W-1:0];
                            c_q     <= c_nxt;
                            state_q <= StPlayWait;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule
